// File: rtl/tiny_logic_analyzer_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tiny_logic_analyzer_pkg
// Shared definitions for the tiny logic analyzer tile:
//   - default parameter values (counter width, glitch threshold, ID byte)
//   - output byte select codes
//   - bit positions inside the status byte
//   - saturating 8-bit increment helper
// -----------------------------------------------------------------------------
package tiny_logic_analyzer_pkg;

    localparam int         CNT_W_DEFAULT     = 16;
    localparam int         GLITCH_TH_DEFAULT = 128;
    localparam logic [7:0] ID_BYTE_DEFAULT   = 8'hA5;

    // Output byte select codes (io_in[5:3])
    typedef enum logic [2:0] {
        SEL_HI_L   = 3'd0,
        SEL_HI_H   = 3'd1,
        SEL_LO_L   = 3'd2,
        SEL_LO_H   = 3'd3,
        SEL_EDGES  = 3'd4,
        SEL_STATUS = 3'd5,
        SEL_GLITCH = 3'd6,
        SEL_ID     = 3'd7
    } sel_e;

    // Bit positions inside the status byte; bits 7..5 read as zero
    localparam int ST_SYNC       = 0;
    localparam int ST_HIGH_VALID = 1;
    localparam int ST_LOW_VALID  = 2;
    localparam int ST_HIGH_SAT   = 3;
    localparam int ST_LOW_SAT    = 4;

    // Increment an 8-bit counter, sticking at 0xFF
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tiny_logic_analyzer_edge_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tla_edge_sync
// Brings the asynchronous probe into the clock domain with a two-flop
// synchroniser, keeps a one-cycle-delayed copy, and flags rising/falling
// edges of the synchronised signal.
// Ports:
//   clk     in   tile clock
//   rst     in   asynchronous active-high reset
//   data_in in   raw asynchronous probe
//   s       out  synchronised probe level
//   rise    out  s went 0 -> 1 this cycle
//   fall    out  s went 1 -> 0 this cycle
// -----------------------------------------------------------------------------
module tla_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync_r;
    logic sync_d_r;

    // Synchroniser chain plus delayed copy used for edge comparison
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync_r   <= 1'b0;
            sync_d_r <= 1'b0;
        end else begin
            sync1_r  <= data_in;
            sync_r   <= sync1_r;
            sync_d_r <= sync_r;
        end
    end

    assign s    = sync_r;
    assign rise = sync_r & ~sync_d_r;
    assign fall = ~sync_r & sync_d_r;

endmodule

// File: rtl/tiny_logic_analyzer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tiny_logic_analyzer
// Single-channel pulse-timing analyzer. Measures the last complete high and
// low time of a probe in clock cycles, counts rising edges and glitches
// (completed pulses shorter than GLITCH_TH), and returns one selected result
// byte per cycle.
// Ports:
//   io_in[0]   clk      tile clock, all state on its rising edge
//   io_in[1]   rst      asynchronous active-high reset
//   io_in[2]   data_in  asynchronous probe
//   io_in[5:3] sel      output byte select (see sel_e)
//   io_in[6]   freeze   1 = hold all latched results
//   io_in[7]   -        ignored
//   io_out     selected result byte, registered (one cycle after sel)
// -----------------------------------------------------------------------------
module tiny_logic_analyzer
    import tiny_logic_analyzer_pkg::*;
#(
    parameter int         CNT_W     = CNT_W_DEFAULT,
    parameter int         GLITCH_TH = GLITCH_TH_DEFAULT,
    parameter logic [7:0] ID_BYTE   = ID_BYTE_DEFAULT
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GLITCH_TH_C = CNT_W'(GLITCH_TH);

    logic       clk;
    logic       rst;
    logic       data_in;
    logic [2:0] sel;
    logic       freeze;
    logic       unused_io_s;

    assign clk         = io_in[0];
    assign rst         = io_in[1];
    assign data_in     = io_in[2];
    assign sel         = io_in[5:3];
    assign freeze      = io_in[6];
    assign unused_io_s = io_in[7];

    logic sync_s;
    logic rise_s;
    logic fall_s;
    logic edge_s;

    tla_edge_sync u_edge_sync (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .s       (sync_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    assign edge_s = rise_s | fall_s;

    logic [CNT_W-1:0] run_cnt_r;
    logic             seen_edge_r;
    logic [CNT_W-1:0] high_w_r;
    logic [CNT_W-1:0] low_w_r;
    logic             high_valid_r;
    logic             low_valid_r;
    logic             high_sat_r;
    logic             low_sat_r;
    logic [7:0]       edge_cnt_r;
    logic [7:0]       glitch_cnt_r;
    logic [7:0]       io_out_r;

    // A run is only a complete pulse once an earlier edge has started it;
    // freeze blocks latching but never the run counter itself.
    logic latch_en_s;
    logic run_sat_s;
    logic run_short_s;

    assign latch_en_s  = seen_edge_r & ~freeze;
    assign run_sat_s   = (run_cnt_r == CNT_MAX);
    assign run_short_s = (run_cnt_r < GLITCH_TH_C);

    // Run-length counter: restarts at 1 on each edge, saturates at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_r   <= {CNT_W{1'b0}};
            seen_edge_r <= 1'b0;
        end else begin
            if (edge_s) begin
                run_cnt_r   <= CNT_ONE;
                seen_edge_r <= 1'b1;
            end else if (!run_sat_s) begin
                run_cnt_r <= run_cnt_r + CNT_ONE;
            end else begin
                run_cnt_r <= run_cnt_r;
            end
        end
    end

    // High-time latch: the run ending at a falling edge was a high pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_w_r     <= {CNT_W{1'b0}};
            high_valid_r <= 1'b0;
            high_sat_r   <= 1'b0;
        end else if (fall_s && latch_en_s) begin
            high_w_r     <= run_cnt_r;
            high_valid_r <= 1'b1;
            high_sat_r   <= run_sat_s;
        end else begin
            high_w_r     <= high_w_r;
            high_valid_r <= high_valid_r;
            high_sat_r   <= high_sat_r;
        end
    end

    // Low-time latch: the run ending at a rising edge was a low pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            low_w_r     <= {CNT_W{1'b0}};
            low_valid_r <= 1'b0;
            low_sat_r   <= 1'b0;
        end else if (rise_s && latch_en_s) begin
            low_w_r     <= run_cnt_r;
            low_valid_r <= 1'b1;
            low_sat_r   <= run_sat_s;
        end else begin
            low_w_r     <= low_w_r;
            low_valid_r <= low_valid_r;
            low_sat_r   <= low_sat_r;
        end
    end

    // Rising-edge counter, wraps; counts even before the first complete pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_r <= 8'h00;
        end else if (rise_s && !freeze) begin
            edge_cnt_r <= edge_cnt_r + 8'd1;
        end else begin
            edge_cnt_r <= edge_cnt_r;
        end
    end

    // Glitch counter: any latched pulse shorter than the threshold, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt_r <= 8'h00;
        end else if (edge_s && latch_en_s && run_short_s) begin
            glitch_cnt_r <= sat_inc8(glitch_cnt_r);
        end else begin
            glitch_cnt_r <= glitch_cnt_r;
        end
    end

    logic [15:0] high_w16_s;
    logic [15:0] low_w16_s;
    logic [7:0]  status_s;
    logic [7:0]  byte_sel_s;

    assign high_w16_s = 16'(high_w_r);
    assign low_w16_s  = 16'(low_w_r);

    // Assemble the status byte from the live flags
    always_comb begin
        status_s                = 8'h00;
        status_s[ST_SYNC]       = sync_s;
        status_s[ST_HIGH_VALID] = high_valid_r;
        status_s[ST_LOW_VALID]  = low_valid_r;
        status_s[ST_HIGH_SAT]   = high_sat_r;
        status_s[ST_LOW_SAT]    = low_sat_r;
    end

    // Result byte chosen by sel
    always_comb begin
        byte_sel_s = 8'h00;
        case (sel_e'(sel))
            SEL_HI_L:   byte_sel_s = high_w16_s[7:0];
            SEL_HI_H:   byte_sel_s = high_w16_s[15:8];
            SEL_LO_L:   byte_sel_s = low_w16_s[7:0];
            SEL_LO_H:   byte_sel_s = low_w16_s[15:8];
            SEL_EDGES:  byte_sel_s = edge_cnt_r;
            SEL_STATUS: byte_sel_s = status_s;
            SEL_GLITCH: byte_sel_s = glitch_cnt_r;
            SEL_ID:     byte_sel_s = ID_BYTE;
            default:    byte_sel_s = 8'h00;
        endcase
    end

    // Registered output byte, one cycle behind sel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_out_r <= 8'h00;
        end else begin
            io_out_r <= byte_sel_s;
        end
    end

    assign io_out = io_out_r;

endmodule

// File: tb/tb_tiny_logic_analyzer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tiny_logic_analyzer
// Directed bench: drives probe pulses of known cycle length and reads back
// the result bytes against hand-computed values.
// -----------------------------------------------------------------------------
module tb_tiny_logic_analyzer;

    logic       clk;
    logic       rst;
    logic       data_in;
    logic [2:0] sel;
    logic       freeze;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int unsigned cyc;
    int unsigned t0;
    int          n_checks;
    int          n_errors;

    assign io_in = {1'b0, freeze, sel, data_in, rst, clk};

    tiny_logic_analyzer dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time pulse lengths exactly
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Change the probe level at a falling clock edge and restart the run timer
    task automatic set_level(input logic lvl);
        data_in = lvl;
        t0      = cyc;
    endtask

    // Wait until the current level has been held for n sampling edges
    task automatic wait_until(input int unsigned n);
        while ((cyc - t0) < n) @(negedge clk);
    endtask

    // Select a byte, let the registered output update, compare
    task automatic check_sel(input string tag, input logic [2:0] s, input logic [7:0] exp);
        sel = s;
        @(negedge clk);
        check(tag, io_out, exp);
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] prev;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        data_in  = 1'b0;
        sel      = 3'd5;
        freeze   = 1'b0;
        t0       = 0;

        // Reset held: output is zero
        hold(5);
        check("rst_out", io_out, 8'h00);
        rst = 1'b0;
        hold(4);
        check("status_pre_edge", io_out, 8'h00);
        hold(20);

        // Long pulses: 6250 high then 6250 low
        set_level(1'b1);                                   // rise 1
        hold(5);
        check_sel("status_first_high", 3'd5, 8'h01);
        check_sel("first_low_not_latched", 3'd2, 8'h00);
        wait_until(6250);
        set_level(1'b0);
        hold(5);
        check_sel("high_w_lo_6250", 3'd0, 8'h6A);
        check_sel("high_w_hi_6250", 3'd1, 8'h18);
        check_sel("status_high_valid", 3'd5, 8'h02);
        wait_until(6250);
        set_level(1'b1);                                   // rise 2
        hold(5);
        check_sel("low_w_lo_6250", 3'd2, 8'h6A);
        check_sel("low_w_hi_6250", 3'd3, 8'h18);
        check_sel("status_both_valid", 3'd5, 8'h07);
        check_sel("glitch_none", 3'd6, 8'h00);
        check_sel("edges_2", 3'd4, 8'h02);

        // Short low glitch of 77 cycles between 300-cycle highs
        wait_until(300);
        set_level(1'b0);
        wait_until(77);
        set_level(1'b1);                                   // rise 3
        hold(5);
        check_sel("low_w_lo_77", 3'd2, 8'h4D);
        check_sel("low_w_hi_77", 3'd3, 8'h00);
        check_sel("glitch_1", 3'd6, 8'h01);
        check_sel("high_w_lo_300", 3'd0, 8'h2C);
        check_sel("high_w_hi_300", 3'd1, 8'h01);
        wait_until(300);
        set_level(1'b0);
        wait_until(300);
        set_level(1'b1);                                   // rise 4
        wait_until(50);
        set_level(1'b0);                                   // 50-cycle high glitch
        hold(5);
        check_sel("high_w_lo_50", 3'd0, 8'h32);
        check_sel("glitch_2", 3'd6, 8'h02);
        wait_until(300);
        set_level(1'b1);                                   // rise 5
        hold(5);
        check_sel("edges_5", 3'd4, 8'h05);
        check_sel("low_w_lo_300", 3'd2, 8'h2C);

        // Freeze across a fall and a rise; release and latch a full width
        wait_until(100);
        freeze = 1'b1;
        wait_until(400);
        set_level(1'b0);
        hold(5);
        check_sel("frz_high_held", 3'd0, 8'h32);
        wait_until(250);
        set_level(1'b1);                                   // rise under freeze
        hold(5);
        check_sel("frz_edges_held", 3'd4, 8'h05);
        check_sel("frz_low_held", 3'd2, 8'h2C);
        hold(20);
        freeze = 1'b0;
        wait_until(200);
        set_level(1'b0);
        hold(5);
        check_sel("unfrz_high_lo_200", 3'd0, 8'hC8);
        check_sel("unfrz_high_hi_200", 3'd1, 8'h00);
        check_sel("unfrz_glitch_2", 3'd6, 8'h02);

        // 250 short pulses: edge counter to 0xFF, glitch counter saturates
        wait_until(150);
        for (int i = 0; i < 250; i++) begin
            set_level(1'b1);
            wait_until(3);
            set_level(1'b0);
            wait_until(3);
        end
        hold(5);
        check_sel("edges_ff", 3'd4, 8'hFF);
        check_sel("glitch_sat", 3'd6, 8'hFF);
        set_level(1'b1);                                   // 256th counted rise
        hold(5);
        check_sel("edges_wrap", 3'd4, 8'h00);

        // Pulse longer than the counter range saturates
        wait_until(65540);
        set_level(1'b0);
        hold(5);
        check_sel("sat_high_lo", 3'd0, 8'hFF);
        check_sel("sat_high_hi", 3'd1, 8'hFF);
        check_sel("sat_status", 3'd5, 8'h0E);
        wait_until(20);
        set_level(1'b1);
        hold(5);
        check_sel("sat_status_after_rise", 3'd5, 8'h0F);
        check_sel("low_w_lo_20", 3'd2, 8'h14);

        // Select sweep: old byte still visible just after sel changes
        sweep_exp[0] = 8'hFF;
        sweep_exp[1] = 8'hFF;
        sweep_exp[2] = 8'h14;
        sweep_exp[3] = 8'h00;
        sweep_exp[4] = 8'h01;
        sweep_exp[5] = 8'h0F;
        sweep_exp[6] = 8'hFF;
        sweep_exp[7] = 8'hA5;
        prev = 8'h14;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            check("sel_latency", io_out, prev);
            @(negedge clk);
            check("sel_sweep", io_out, sweep_exp[i]);
            prev = sweep_exp[i];
        end

        // Asynchronous reset mid-cycle with the probe high
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out", io_out, 8'h00);
        hold(3);
        rst = 1'b0;
        set_level(1'b1);
        hold(5);
        check_sel("post_rst_status", 3'd5, 8'h01);
        check_sel("post_rst_edges", 3'd4, 8'h01);
        check_sel("post_rst_high_w", 3'd0, 8'h00);
        wait_until(40);
        set_level(1'b0);
        hold(5);
        check_sel("post_rst_high_w_40", 3'd0, 8'h28);
        check_sel("post_rst_glitch", 3'd6, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
